ssd_display_scheduler: RTL



---
 rtl/ssd_display_scheduler_pkg.sv | 18 +
 rtl/ssd_display_scheduler_if.sv | 25 ++
 rtl/ssd_scan_timer.sv | 61 ++++++
 rtl/ssd_display_scheduler.sv | 103 ++++++++++
 4 files changed

// File: rtl/ssd_display_scheduler_pkg.sv
// rtl/ssd_display_scheduler_pkg.sv - shared types and constants for the SSD display scheduler
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int DIGIT_W            = 4;
    localparam int DEFAULT_PRESCALE_W = 18;

    // Digit n of a packed display value lives at bits [4n+3:4n].
    function automatic logic [DIGIT_W-1:0] digit_nibble(input logic [15:0] value, input int n);
        return value[n*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/ssd_display_scheduler_if.sv
// rtl/ssd_display_scheduler_if.sv - requester inputs and decoder-facing outputs of the scheduler
interface ssd_display_scheduler_if;
    logic        req0;
    logic [15:0] val0;
    logic        req1;
    logic [15:0] val1;
    logic [1:0]  ssdscan_clk;
    logic [3:0]  SSD3;
    logic [3:0]  SSD2;
    logic [3:0]  SSD1;
    logic [3:0]  SSD0;
    logic        blank;
    logic [1:0]  grant;
    logic        frame_tick;

    modport master (
        output req0, val0, req1, val1,
        input  ssdscan_clk, SSD3, SSD2, SSD1, SSD0, blank, grant, frame_tick
    );

    modport slave (
        input  req0, val0, req1, val1,
        output ssdscan_clk, SSD3, SSD2, SSD1, SSD0, blank, grant, frame_tick
    );
endinterface

// File: rtl/ssd_scan_timer.sv
// rtl/ssd_scan_timer.sv - prescaler, digit select counter, dead-time counter and frame pulse
module ssd_scan_timer #(
    parameter int PRESCALE_W  = 18,
    parameter int DEAD_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [1:0] scan_o,
    output logic       frame_boundary_o,
    output logic       frame_tick_o,
    output logic       dead_blank_o
);

    localparam int DEAD_W = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [1:0]            scan_q, scan_d;
    logic [DEAD_W-1:0]     dead_q, dead_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  digit_tick;
    logic                  frame_boundary;

    assign digit_tick     = &presc_q;
    assign frame_boundary = digit_tick && (scan_q == 2'd3);

    // The dead counter is loaded on the same edge the select moves, so blanking
    // covers the first DEAD_CYCLES clocks of the new digit.
    always_comb begin
        presc_d      = presc_q + 1'b1;
        scan_d       = scan_q;
        dead_d       = dead_q;
        frame_tick_d = frame_boundary;
        if (digit_tick) begin
            scan_d = scan_q + 2'd1;
            dead_d = DEAD_LOAD;
        end else if (dead_q != '0) begin
            dead_d = dead_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc_q      <= '0;
            scan_q       <= 2'd0;
            dead_q       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            scan_q       <= scan_d;
            dead_q       <= dead_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign scan_o           = scan_q;
    assign frame_boundary_o = frame_boundary;
    assign frame_tick_o     = frame_tick_q;
    assign dead_blank_o     = (dead_q != '0);

endmodule

// File: rtl/ssd_display_scheduler.sv
// rtl/ssd_display_scheduler.sv - two-requester seven-segment scan scheduler with frame snapshot
module ssd_display_scheduler
    import ssd_pkg::*;
#(
    parameter int PRESCALE_W      = DEFAULT_PRESCALE_W,
    parameter int DEAD_CYCLES     = 64,
    parameter int MIN_HOLD_FRAMES = 8
) (
    input  logic                   ClkPort,
    input  logic                   Reset_n,
    ssd_display_scheduler_if.slave dsp
);

    localparam int HOLD_W = (MIN_HOLD_FRAMES < 1) ? 1 : $clog2(MIN_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(MIN_HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [15:0]       snap_q, snap_d;
    logic [1:0]        grant;
    logic [1:0]        scan;
    logic              frame_boundary;
    logic              frame_tick;
    logic              dead_blank;

    ssd_scan_timer #(
        .PRESCALE_W  (PRESCALE_W),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_scan_timer (
        .clk_i            (ClkPort),
        .rst_ni           (Reset_n),
        .scan_o           (scan),
        .frame_boundary_o (frame_boundary),
        .frame_tick_o     (frame_tick),
        .dead_blank_o     (dead_blank)
    );

    // Arbitration, hold and snapshot all move on the frame boundary edge so the
    // new owner's value appears together with digit 0.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        snap_d  = snap_q;
        if (frame_boundary) begin
            case (state_q)
                ST_IDLE: begin
                    if (dsp.req0)      state_d = ST_OWN0;
                    else if (dsp.req1) state_d = ST_OWN1;
                end
                ST_OWN0: begin
                    if (!dsp.req0) state_d = dsp.req1 ? ST_OWN1 : ST_IDLE;
                end
                ST_OWN1: begin
                    if (!dsp.req1)                         state_d = dsp.req0 ? ST_OWN0 : ST_IDLE;
                    else if (dsp.req0 && hold_q >= HOLD_MIN) state_d = ST_OWN0;
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_d != state_q)    hold_d = {{(HOLD_W-1){1'b0}}, 1'b1};
            else if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;

            case (state_d)
                ST_OWN0: snap_d = dsp.val0;
                ST_OWN1: snap_d = dsp.val1;
                default: snap_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            snap_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (state_q)
            ST_OWN0: grant = 2'b01;
            ST_OWN1: grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign dsp.ssdscan_clk = scan;
    assign dsp.SSD3        = digit_nibble(snap_q, 3);
    assign dsp.SSD2        = digit_nibble(snap_q, 2);
    assign dsp.SSD1        = digit_nibble(snap_q, 1);
    assign dsp.SSD0        = digit_nibble(snap_q, 0);
    assign dsp.grant       = grant;
    assign dsp.frame_tick  = frame_tick;
    // With no owner the anodes stay dark regardless of the dead-time window.
    assign dsp.blank       = dead_blank | (state_q == ST_IDLE);

endmodule
